// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns single-beat reads/writes into one-cycle strobes on a
// simple register-file port. Only one transaction is in flight at a time.
module axil_reg_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 0
) (
  input  logic                  axil_aclk,
  input  logic                  axil_rst,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_awaddr,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [1:0]            s_axil_bresp,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  input  logic [31:0]           s_axil_araddr,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  reg_en,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_din,
  input  logic [DATA_WIDTH-1:0] reg_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    WR_RESP = 3'd2,
    RD_ACC  = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         LAT_M1_I    = (RD_LATENCY > 0) ? (RD_LATENCY - 1) : 0;
  localparam logic [1:0] LAT_M1      = LAT_M1_I[1:0];

  // Any address bit above the word-index field is outside the register file.
  function automatic logic addr_out_of_range(input logic [31:0] addr);
    return (addr >> (ADDR_WIDTH + 2)) != 32'd0;
  endfunction

  state_t                state_r, state_n;
  logic                  aw_lat_r, aw_lat_n, w_lat_r, w_lat_n, ar_lat_r, ar_lat_n;
  logic [ADDR_WIDTH-1:0] aw_idx_r, aw_idx_n, ar_idx_r, ar_idx_n;
  logic                  aw_dec_r, aw_dec_n, ar_dec_r, ar_dec_n;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_n;
  logic [3:0]            wstrb_r, wstrb_n;
  logic                  last_wr_r, last_wr_n;
  logic [1:0]            cnt_r, cnt_n;
  logic                  awready_r, awready_n, wready_r, wready_n, arready_r, arready_n;
  logic                  bvalid_r, bvalid_n, rvalid_r, rvalid_n;
  logic [1:0]            bresp_r, bresp_n, rresp_r, rresp_n;
  logic [31:0]           rdata_r, rdata_n;
  logic                  reg_en_r, reg_en_n, reg_we_r, reg_we_n;
  logic [ADDR_WIDTH-1:0] reg_addr_r, reg_addr_n;
  logic [DATA_WIDTH-1:0] reg_din_r, reg_din_n;
  logic                  aw_hs_s, w_hs_s, ar_hs_s, wr_rdy_s, rd_rdy_s, grant_wr_s, grant_rd_s;

  // Readies are forced low combinationally so none is offered while reset is high.
  assign s_axil_awready = awready_r & ~axil_rst;
  assign s_axil_wready  = wready_r & ~axil_rst;
  assign s_axil_arready = arready_r & ~axil_rst;
  assign s_axil_bvalid  = bvalid_r;
  assign s_axil_bresp   = bresp_r;
  assign s_axil_rvalid  = rvalid_r;
  assign s_axil_rresp   = rresp_r;
  assign s_axil_rdata   = rdata_r;
  assign reg_en         = reg_en_r;
  assign reg_we         = reg_we_r;
  assign reg_addr       = reg_addr_r;
  assign reg_din        = reg_din_r;

  assign aw_hs_s    = s_axil_awvalid & s_axil_awready;
  assign w_hs_s     = s_axil_wvalid & s_axil_wready;
  assign ar_hs_s    = s_axil_arvalid & s_axil_arready;
  assign wr_rdy_s   = aw_lat_r & w_lat_r;
  assign rd_rdy_s   = ar_lat_r;
  // last_wr_r set means the write side was granted last, so a tied read goes first.
  assign grant_wr_s = (state_r == IDLE) & wr_rdy_s & (~rd_rdy_s | ~last_wr_r);
  assign grant_rd_s = (state_r == IDLE) & rd_rdy_s & (~wr_rdy_s | last_wr_r);

  // State, request latches and all registered outputs.
  always_ff @(posedge axil_aclk) begin
    if (axil_rst) begin
      state_r    <= IDLE;
      aw_lat_r   <= 1'b0;
      w_lat_r    <= 1'b0;
      ar_lat_r   <= 1'b0;
      aw_idx_r   <= '0;
      ar_idx_r   <= '0;
      aw_dec_r   <= 1'b0;
      ar_dec_r   <= 1'b0;
      wdata_r    <= '0;
      wstrb_r    <= 4'h0;
      last_wr_r  <= 1'b0;
      cnt_r      <= 2'd0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      arready_r  <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
      rvalid_r   <= 1'b0;
      rresp_r    <= 2'b00;
      rdata_r    <= 32'd0;
      reg_en_r   <= 1'b0;
      reg_we_r   <= 1'b0;
      reg_addr_r <= '0;
      reg_din_r  <= '0;
    end else begin
      state_r    <= state_n;
      aw_lat_r   <= aw_lat_n;
      w_lat_r    <= w_lat_n;
      ar_lat_r   <= ar_lat_n;
      aw_idx_r   <= aw_idx_n;
      ar_idx_r   <= ar_idx_n;
      aw_dec_r   <= aw_dec_n;
      ar_dec_r   <= ar_dec_n;
      wdata_r    <= wdata_n;
      wstrb_r    <= wstrb_n;
      last_wr_r  <= last_wr_n;
      cnt_r      <= cnt_n;
      awready_r  <= awready_n;
      wready_r   <= wready_n;
      arready_r  <= arready_n;
      bvalid_r   <= bvalid_n;
      bresp_r    <= bresp_n;
      rvalid_r   <= rvalid_n;
      rresp_r    <= rresp_n;
      rdata_r    <= rdata_n;
      reg_en_r   <= reg_en_n;
      reg_we_r   <= reg_we_n;
      reg_addr_r <= reg_addr_n;
      reg_din_r  <= reg_din_n;
    end
  end

  // Next-state, latch capture, arbitration and next output values.
  always_comb begin
    state_n    = state_r;
    aw_lat_n   = aw_lat_r | aw_hs_s;
    w_lat_n    = w_lat_r | w_hs_s;
    ar_lat_n   = ar_lat_r | ar_hs_s;
    aw_idx_n   = aw_idx_r;
    aw_dec_n   = aw_dec_r;
    ar_idx_n   = ar_idx_r;
    ar_dec_n   = ar_dec_r;
    wdata_n    = wdata_r;
    wstrb_n    = wstrb_r;
    last_wr_n  = last_wr_r;
    cnt_n      = cnt_r;
    bvalid_n   = bvalid_r;
    bresp_n    = bresp_r;
    rvalid_n   = rvalid_r;
    rresp_n    = rresp_r;
    rdata_n    = rdata_r;
    reg_en_n   = 1'b0;
    reg_we_n   = 1'b0;
    reg_addr_n = reg_addr_r;
    reg_din_n  = reg_din_r;

    if (aw_hs_s) begin
      aw_idx_n = s_axil_awaddr[ADDR_WIDTH+1:2];
      aw_dec_n = addr_out_of_range(s_axil_awaddr);
    end else begin
      aw_idx_n = aw_idx_r;
    end
    if (w_hs_s) begin
      wdata_n = s_axil_wdata;
      wstrb_n = s_axil_wstrb;
    end else begin
      wdata_n = wdata_r;
    end
    if (ar_hs_s) begin
      ar_idx_n = s_axil_araddr[ADDR_WIDTH+1:2];
      ar_dec_n = addr_out_of_range(s_axil_araddr);
    end else begin
      ar_idx_n = ar_idx_r;
    end

    case (state_r)
      IDLE: begin
        if (grant_wr_s) begin
          aw_lat_n  = 1'b0;
          w_lat_n   = 1'b0;
          last_wr_n = 1'b1;
          if (aw_dec_r) begin
            state_n  = WR_RESP;
            bvalid_n = 1'b1;
            bresp_n  = RESP_DECERR;
          end else if (wstrb_r != 4'hF) begin
            state_n  = WR_RESP;
            bvalid_n = 1'b1;
            bresp_n  = RESP_SLVERR;
          end else begin
            state_n    = WR_ACC;
            reg_en_n   = 1'b1;
            reg_we_n   = 1'b1;
            reg_addr_n = aw_idx_r;
            reg_din_n  = wdata_r;
          end
        end else if (grant_rd_s) begin
          ar_lat_n  = 1'b0;
          last_wr_n = 1'b0;
          if (ar_dec_r) begin
            state_n  = RD_RESP;
            rvalid_n = 1'b1;
            rresp_n  = RESP_DECERR;
            rdata_n  = 32'd0;
          end else begin
            state_n    = RD_ACC;
            reg_en_n   = 1'b1;
            reg_addr_n = ar_idx_r;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WR_ACC: begin
        state_n  = WR_RESP;
        bvalid_n = 1'b1;
        bresp_n  = RESP_OKAY;
      end
      WR_RESP: begin
        if (s_axil_bready) begin
          state_n  = IDLE;
          bvalid_n = 1'b0;
        end else begin
          state_n = WR_RESP;
        end
      end
      RD_ACC: begin
        if (RD_LATENCY == 0) begin
          state_n  = RD_RESP;
          rvalid_n = 1'b1;
          rresp_n  = RESP_OKAY;
          rdata_n  = reg_dout;
        end else begin
          state_n = RD_WAIT;
          cnt_n   = LAT_M1;
        end
      end
      RD_WAIT: begin
        if (cnt_r == 2'd0) begin
          state_n  = RD_RESP;
          rvalid_n = 1'b1;
          rresp_n  = RESP_OKAY;
          rdata_n  = reg_dout;
        end else begin
          cnt_n = cnt_r - 2'd1;
        end
      end
      RD_RESP: begin
        if (s_axil_rready) begin
          state_n  = IDLE;
          rvalid_n = 1'b0;
        end else begin
          state_n = RD_RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    awready_n = (state_n == IDLE) & ~aw_lat_n;
    wready_n  = (state_n == IDLE) & ~w_lat_n;
    arready_n = (state_n == IDLE) & ~aw_lat_n & ~w_lat_n & ~ar_lat_n;
  end

endmodule
